// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch front end: default widths, FIFO depth and
// the fetch FSM state encoding.
package cpu_pkg;

  localparam int unsigned IfAddrWidth = 9;
  localparam int unsigned IfDataWidth = 32;
  localparam logic [1:0]  FifoDepth   = 2'd2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDrop = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ifetch_fifo.sv
// Two-entry instruction buffer between the memory response and decode.
// Flush empties it on the next edge regardless of push or pop.
module ifetch_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned Width = IfDataWidth + IfAddrWidth
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic [1:0]       count_o
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  // A full buffer still accepts a push when the head leaves on the same edge.
  assign do_push = push_i && ((count_q != FifoDepth) || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ifetch_stage.sv
// Instruction fetch: one outstanding memory request at a time, responses
// buffered in a 2-entry FIFO and handed to decode with a valid/ready handshake.
module ifetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned N = IfAddrWidth,
  parameter int unsigned W = IfDataWidth
) (
  input  logic         btn,
  input  logic         rst,
  input  logic [N-1:0] pc,
  input  logic         flush,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_gnt,
  input  logic         imem_rvalid,
  input  logic [W-1:0] imem_rdata,
  output logic         inst_valid,
  input  logic         inst_ready,
  output logic [W-1:0] inst,
  output logic [N-1:0] inst_pc,
  output logic         pc_adv,
  output logic [N-1:0] npc
);

  fetch_state_e   state_q;
  logic [N-1:0]   tag_q;
  logic [1:0]     fifo_count;
  logic [W+N-1:0] fifo_out;
  logic           push;
  logic           pop;

  // Requests only from IDLE, so a response can never find the FIFO full.
  assign imem_req  = rst && (state_q == StIdle) && !flush && (fifo_count < FifoDepth);
  assign imem_addr = pc;
  assign pc_adv    = imem_req && imem_gnt;
  assign npc       = pc + {{(N-1){1'b0}}, 1'b1};

  assign push       = (state_q == StWait) && imem_rvalid && !flush;
  assign inst_valid = (fifo_count != 2'd0);
  assign pop        = inst_valid && inst_ready;
  assign inst       = fifo_out[W+N-1:N];
  assign inst_pc    = fifo_out[N-1:0];

  always_ff @(posedge btn or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      tag_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (pc_adv) begin
            tag_q   <= pc;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (imem_rvalid) begin
            state_q <= StIdle;
          end else if (flush) begin
            state_q <= StDrop;
          end
        end
        StDrop: begin
          if (imem_rvalid) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  ifetch_fifo #(
    .Width(W + N)
  ) u_fifo (
    .clk_i  (btn),
    .rst_ni (rst),
    .flush_i(flush),
    .push_i (push),
    .data_i ({imem_rdata, tag_q}),
    .pop_i  (pop),
    .data_o (fifo_out),
    .count_o(fifo_count)
  );

endmodule

// File: tb/tb_ifetch_stage.sv
// Self-checking bench for ifetch_stage: randomized memory/decode traffic with a
// queue-based reference of delivered instructions and a per-cycle monitor.
module tb_ifetch_stage;

  localparam int unsigned N = 9;
  localparam int unsigned W = 32;

  logic         btn = 1'b0;
  logic         rst;
  logic [N-1:0] pc;
  logic         flush;
  logic         imem_req;
  logic [N-1:0] imem_addr;
  logic         imem_gnt;
  logic         imem_rvalid;
  logic [W-1:0] imem_rdata;
  logic         inst_valid;
  logic         inst_ready;
  logic [W-1:0] inst;
  logic [N-1:0] inst_pc;
  logic         pc_adv;
  logic [N-1:0] npc;

  ifetch_stage #(.N(N), .W(W)) dut (
    .btn        (btn),
    .rst        (rst),
    .pc         (pc),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .pc_adv     (pc_adv),
    .npc        (npc)
  );

  always #5 btn = ~btn;

  // Reference state: expected decode stream and the memory's view of the
  // single outstanding request.
  logic [W+N-1:0] exp_q[$];
  logic [N-1:0]   pc_q;
  logic [N-1:0]   req_tag;
  bit             busy;
  bit             dropped;
  int             lat;
  int             lat_max;
  bit             redirect_en;
  logic           rst_next;
  int             n_pass;
  int             n_total;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic cycle(input bit f, input bit g, input bit rv, input bit sp,
                       input logic [W-1:0] rd, input bit rdy);
    @(negedge btn);
    rst         = rst_next;
    pc          = pc_q;
    flush       = f;
    imem_gnt    = g;
    imem_rvalid = busy ? (rv && lat == 0) : (rv && sp);
    imem_rdata  = rd;
    inst_ready  = rdy;
    #2;
    if (rst) begin
      if (flush) exp_q.delete();
      if (busy) begin
        if (imem_rvalid) begin
          if (!dropped && !flush) exp_q.push_back({rd, req_tag});
          busy = 0;
        end else begin
          if (flush) dropped = 1;
          if (lat > 0) lat--;
        end
      end
      if (imem_req && imem_gnt) begin
        busy    = 1;
        dropped = 0;
        req_tag = pc;
        lat     = $urandom_range(0, lat_max);
        pc_q    = N'((int'(pc) + 1) % (1 << N));
      end
      if (flush && redirect_en) pc_q = ($urandom % 4 == 0) ? 9'h1FE : N'($urandom);
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, '0, rdy);
  endtask

  // Monitor: samples after inputs settle, compares against the reference.
  logic [N-1:0] exp_npc;
  bit           exp_req;
  always begin
    @(negedge btn);
    #1;
    exp_npc = N'((int'(pc) + 1) % (1 << N));
    chk("npc", 64'(npc), 64'(exp_npc));
    if (!rst) begin
      chk("rst_inst_valid", 64'(inst_valid), 64'd0);
      chk("rst_imem_req", 64'(imem_req), 64'd0);
      chk("rst_pc_adv", 64'(pc_adv), 64'd0);
    end else begin
      exp_req = !busy && !flush && (exp_q.size() < 2);
      chk("imem_req", 64'(imem_req), 64'(exp_req));
      if (exp_req) chk("imem_addr", 64'(imem_addr), 64'(pc));
      chk("pc_adv", 64'(pc_adv), 64'(exp_req && imem_gnt));
      chk("inst_valid", 64'(inst_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("inst_head", 64'({inst, inst_pc}), 64'(exp_q[0]));
        if (inst_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    n_pass = 0; n_total = 0;
    busy = 0; dropped = 0; lat = 0; lat_max = 0; redirect_en = 0;
    rst = 1'b0; rst_next = 1'b0; pc_q = '0; pc = '0; flush = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0; inst_ready = 0;
    idle(2, 1);

    // First fetch after reset release, single-cycle memory.
    rst_next = 1'b1;
    cycle(0, 1, 0, 0, '0, 1);
    cycle(0, 0, 1, 0, 32'h2001_0005, 1);
    idle(2, 1);

    // Decode stalled: two fetches fill the FIFO, head holds, then drains in order.
    pc_q = 9'h004;
    cycle(0, 1, 0, 0, '0, 0);
    cycle(0, 0, 1, 0, 32'hAAAA_0004, 0);
    cycle(0, 1, 0, 0, '0, 0);
    cycle(0, 0, 1, 0, 32'hBBBB_0005, 0);
    cycle(0, 1, 0, 0, '0, 0);
    idle(3, 0);
    idle(3, 1);

    // Flush while waiting: late response is dropped, fetching resumes.
    pc_q = 9'h010;
    cycle(0, 1, 0, 0, '0, 1);
    cycle(1, 0, 0, 0, '0, 1);
    cycle(0, 0, 0, 0, '0, 1);
    cycle(0, 0, 1, 0, 32'hDEAD_0010, 1);
    cycle(0, 1, 0, 0, '0, 1);
    cycle(0, 0, 1, 0, 32'h1234_5678, 1);
    idle(2, 1);

    // PC wrap.
    pc_q = 9'h1FF;
    cycle(0, 0, 0, 0, '0, 1);
    chk("npc_wrap", 64'(npc), 64'd0);

    // Flush with response and pop together at count=1.
    pc_q = 9'h020;
    cycle(0, 1, 0, 0, '0, 0);
    cycle(0, 0, 1, 0, 32'h0000_0020, 0);
    cycle(0, 1, 0, 0, '0, 0);
    cycle(1, 0, 1, 0, 32'hBAD0_0021, 1);
    cycle(0, 0, 0, 0, '0, 1);
    chk("flush_empty", 64'(inst_valid), 64'd0);
    idle(1, 1);

    // Asynchronous reset while waiting with a buffered instruction.
    pc_q = 9'h030;
    cycle(0, 1, 0, 0, '0, 0);
    cycle(0, 0, 1, 0, 32'h0000_0030, 0);
    cycle(0, 1, 0, 0, '0, 0);
    #1;
    rst = 1'b0; rst_next = 1'b0;
    exp_q.delete(); busy = 0; dropped = 0; lat = 0;
    #1;
    chk("async_rst_valid", 64'(inst_valid), 64'd0);
    chk("async_rst_req", 64'(imem_req), 64'd0);
    idle(2, 1);
    rst_next = 1'b1;
    pc_q = 9'h0AB;
    cycle(0, 1, 0, 0, '0, 1);
    cycle(0, 0, 1, 0, 32'h0000_00AB, 1);
    idle(2, 1);

    // Randomized traffic.
    lat_max = 2; redirect_en = 1;
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom % 12) == 0, ($urandom % 2) == 0, ($urandom % 4) != 0,
            ($urandom % 5) == 0, $urandom, ($urandom % 3) != 0);
    end
    lat_max = 0; redirect_en = 0;
    idle(4, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
